mem_vec_seq: RTL
================

MEM_VEC_SEQ -- requirements
Module: mem_vec_seq

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have start in 1: pulse requesting a vector memory operation; sampled only in IDLE.
REQ-003 SHALL have is_load in 1 and is_store in 1: operation type qualifiers for start.
REQ-004 SHALL have addr in 32 (base byte address), VL in 2 (vector length code), wdata512 in 512 (store data).
REQ-005 SHALL have memory port: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32.
REQ-006 SHALL have pipeline outputs: stall out 1, done out 1, err out 1, readdata512 out 512 (feeds the MEM/WB register).

Function
REQ-007 SHALL decode beat count N from VL: 00=4, 01=8, 10=16, 11=16 (11 reserved, treated as 512-bit).
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_R, DONE.
REQ-009 IDLE: start with exactly one of is_load/is_store and addr[1:0]==0 SHALL latch addr, VL, wdata512, clear beat counter, clear readdata512, go to REQ.
REQ-010 IDLE: start with both or neither qualifier, or addr[1:0]!=0, SHALL pulse err one cycle, issue no access, stay in IDLE.
REQ-011 REQ: mem_req=1, mem_addr=base+4*beat (32-bit wrap), mem_we=1 for store; held stable until mem_gnt.
REQ-012 REQ with mem_gnt, store: mem_wdata=wdata512[32*beat+:32]; beat increments; last beat -> DONE, else stay in REQ.
REQ-013 REQ with mem_gnt, load: -> WAIT_R; mem_req low in WAIT_R (one outstanding access max).
REQ-014 WAIT_R with mem_rvalid: readdata512[32*beat+:32]<=mem_rdata; beat increments; last beat -> DONE, else -> REQ.
REQ-015 mem_rvalid outside WAIT_R SHALL be ignored.
REQ-016 DONE: done=1 for exactly one cycle, then -> IDLE; readdata512 holds value until next accepted start.
REQ-017 Words above N-1 in readdata512 SHALL read zero after a short-VL load.
REQ-018 stall SHALL be combinational: 1 when state in {REQ, WAIT_R} or (IDLE and start accepted per REQ-009); 0 in DONE.
REQ-019 start while not IDLE SHALL be ignored.
REQ-020 mem_we, mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-021 reset SHALL asynchronously force IDLE, beat=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, done=0, err=0, readdata512=0, latched regs=0.
REQ-022 reset mid-operation SHALL abort the access; a later mem_rvalid/mem_gnt SHALL be ignored in IDLE.

Configuration
REQ-023 Macro MEM_VEC_SEQ_TIMEOUT_EN defined: counter SHALL count consecutive cycles in REQ without mem_gnt or in WAIT_R without mem_rvalid; reaching 16 SHALL pulse err, drop mem_req, go to IDLE without done.
REQ-024 Macro undefined: no timeout logic; FSM SHALL wait indefinitely.

Structure
REQ-025 Package mem_vec_pkg SHALL hold the state enum, VL codes, beat-count decode function, BEAT_W=32, VEC_W=512, TIMEOUT_CYC=16.
REQ-026 One sub-module mem_vec_timeout (cycle counter, clear/increment/expire) SHALL be instantiated only under MEM_VEC_SEQ_TIMEOUT_EN.

Verification
REQ-027 Load VL=00, addr=0x100, memory returns 0x11,0x22,0x33,0x44 with gnt/rvalid next cycle -> addrs 0x100..0x10C, readdata512[127:0]=0x00000044_00000033_00000022_00000011, upper bits 0, one done pulse, stall high until DONE.
REQ-028 Store VL=10, addr=0x200, wdata512 word i = i -> 16 granted writes to 0x200..0x23C with mem_wdata=0..15, mem_we=1, done pulse.
REQ-029 Load VL=01 with mem_gnt delayed 3 cycles per beat -> mem_req/mem_addr stable while waiting, 8 beats complete, result correct.
REQ-030 start with addr=0x102, or is_load=is_store=1 -> err pulse, mem_req stays 0, stall 0, no done.
REQ-031 reset asserted during beat 5 of VL=10 load -> all outputs 0 immediately; stray mem_rvalid next cycle ignored; fresh load afterward correct.
REQ-032 With MEM_VEC_SEQ_TIMEOUT_EN, mem_gnt held 0 -> err after 16 cycles in REQ, mem_req drops, no done; without macro, mem_req held indefinitely.

Source files
------------

// File: rtl/mem_vec_pkg.sv
// Shared types and constants for the vector memory sequencer.
// Holds the FSM state encoding, VL codes and the beat-count decode.
// Backpressure: not applicable (types only).
package mem_vec_pkg;

    localparam int BEAT_W      = 32;
    localparam int VEC_W       = 512;
    localparam int NUM_WORDS   = VEC_W / BEAT_W;
    localparam int BEAT_IDX_W  = 4;
    localparam int TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        VL_128  = 2'b00,
        VL_256  = 2'b01,
        VL_512  = 2'b10,
        VL_RSVD = 2'b11
    } vl_t;

    // Reserved code 11 is treated as a full 512-bit vector.
    function automatic logic [4:0] beat_count(input logic [1:0] vl);
        logic [4:0] n;
        n = 5'd16;
        case (vl)
            VL_128:  n = 5'd4;
            VL_256:  n = 5'd8;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_vec_timeout.sv
// Counts consecutive stalled cycles and flags expiry at TIMEOUT_CYC.
// Latency: expire is combinational on the TIMEOUT_CYC-th stalled cycle.
// Backpressure: none; clear has priority over inc.
module mem_vec_timeout
    import mem_vec_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt;

    assign expire = inc && !clear && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_vec_seq.sv
// Sequences a 128/256/512-bit vector load/store into 32-bit memory beats.
// Latency: one beat per grant (store) or grant+rvalid (load), DONE one cycle after last beat.
// Backpressure: holds mem_req/mem_addr until mem_gnt; stall held while busy. Optional MEM_VEC_SEQ_TIMEOUT_EN.
module mem_vec_seq
    import mem_vec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [31:0]       addr,
    input  logic [1:0]        VL,
    input  logic [VEC_W-1:0]  wdata512,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [VEC_W-1:0]  readdata512
);

    state_t                state, state_nxt;
    logic [BEAT_IDX_W-1:0] beat;
    logic [31:0]           base_addr;
    logic [1:0]            vl_q;
    logic [VEC_W-1:0]      wdata_q;
    logic                  store_q;

    logic start_ok;
    logic start_bad;
    logic accept;
    logic last_beat;
    logic beat_inc;
    logic rd_capture;
    logic tmo_expire;

    assign start_ok  = start && (is_load ^ is_store) && (addr[1:0] == 2'b00);
    assign start_bad = start && !start_ok;
    assign accept    = (state == ST_IDLE) && start_ok;
    assign last_beat = ({1'b0, beat} == (beat_count(vl_q) - 5'd1));

`ifdef MEM_VEC_SEQ_TIMEOUT_EN
    logic tmo_inc;

    // Any cycle that makes progress (grant or read data) restarts the count.
    assign tmo_inc = ((state == ST_REQ) && !mem_gnt) ||
                     ((state == ST_WAIT_R) && !mem_rvalid);

    mem_vec_timeout u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!tmo_inc),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        beat_inc   = 1'b0;
        rd_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                end else if (mem_gnt) begin
                    if (store_q) begin
                        beat_inc  = 1'b1;
                        state_nxt = last_beat ? ST_DONE : ST_REQ;
                    end else begin
                        state_nxt = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                if (tmo_expire) begin
                    state_nxt = ST_IDLE;
                end else if (mem_rvalid) begin
                    rd_capture = 1'b1;
                    beat_inc   = 1'b1;
                    state_nxt  = last_beat ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from state so reset clears them immediately.
    assign mem_req   = (state == ST_REQ);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = mem_req ? (base_addr + {26'd0, beat, 2'b00}) : 32'd0;
    assign mem_wdata = mem_we ? wdata_q[{beat, 5'b00000} +: BEAT_W] : '0;
    assign stall     = (state == ST_REQ) || (state == ST_WAIT_R) || accept;
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat        <= '0;
            base_addr   <= '0;
            vl_q        <= '0;
            wdata_q     <= '0;
            store_q     <= 1'b0;
            readdata512 <= '0;
            err         <= 1'b0;
        end else begin
            err <= ((state == ST_IDLE) && start_bad) || tmo_expire;
            if (accept) begin
                base_addr   <= addr;
                vl_q        <= VL;
                wdata_q     <= wdata512;
                store_q     <= is_store;
                beat        <= '0;
                readdata512 <= '0;
            end else begin
                if (rd_capture) begin
                    readdata512[{beat, 5'b00000} +: BEAT_W] <= mem_rdata;
                end
                if (beat_inc) begin
                    beat <= beat + BEAT_IDX_W'(1);
                end
            end
        end
    end

endmodule
